ifu_line_fetcher: RTL and testbench

Instruction-fetch line requester that sits between the instruction buffer and the memory arbiter. It turns `fetch_inst` refill pulses and backend redirects into line-aligned 64-byte read requests, issues them on the `pc_index` handshake, and captures the returned 512-bit line. It delivers each line to the instruction buffer as a one-cycle `pc_operation_done` with a stable `pc`. On a redirect it generates `clear_ibuffer` and discards any request already in flight.

---
 rtl/ifu_line_fetcher_pkg.sv | 23 ++
 rtl/ifu_line_fetcher.sv | 143 ++++++++++++++
 tb/tb_ifu_line_fetcher.sv | 212 +++++++++++++++++++++
 3 files changed

// File: rtl/ifu_line_fetcher_pkg.sv
// Shared frontend definitions for the instruction-fetch line requester:
// FSM state encoding and fetch-line geometry constants.
package ifu_line_fetcher_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } ifu_state_t;

  localparam int LINE_BYTES       = 64;
  localparam int LINE_OFFSET_BITS = 6;
  localparam int INSTS_PER_LINE   = 16;

  // First 32-bit instruction slot addressed by a byte offset in a line.
  function automatic logic [3:0] slot_of(
    input logic [LINE_OFFSET_BITS-1:0] off
  );
    return off[LINE_OFFSET_BITS-1:2];
  endfunction

endpackage

// File: rtl/ifu_line_fetcher.sv
// Instruction-fetch line requester between instruction buffer and arbiter.
// Issues 64-byte line reads, delivers lines, flushes on redirect.
//
// Ports:
//   clock, reset        : rising-edge clock, async active-high reset
//   fetch_inst          : refill pulse from the instruction buffer
//   redirect_valid/_target : backend redirect strobe and address
//   pc_index_ready      : arbiter response strobe, pc_read_inst valid
//   pc_read_inst        : returned line data
//   pc_index_valid/pc_index : line read request to the arbiter
//   pc_operation_done   : one-cycle line-delivered strobe
//   pc, fetch_line, start_slot : delivered line address, data, first slot
//   clear_ibuffer       : one-cycle flush pulse
//   can_fetch_inst      : block accepts fetch_inst this cycle
module ifu_line_fetcher
  import ifu_line_fetcher_pkg::*;
#(
  parameter int                  PC_WIDTH  = 48,
  parameter logic [PC_WIDTH-1:0] RESET_PC  = '0,
  parameter int                  LINE_BITS = 512
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 fetch_inst,
  input  logic                 redirect_valid,
  input  logic [PC_WIDTH-1:0]  redirect_target,
  input  logic                 pc_index_ready,
  input  logic [LINE_BITS-1:0] pc_read_inst,
  output logic                 pc_index_valid,
  output logic [PC_WIDTH-1:0]  pc_index,
  output logic                 pc_operation_done,
  output logic [PC_WIDTH-1:0]  pc,
  output logic [LINE_BITS-1:0] fetch_line,
  output logic [3:0]           start_slot,
  output logic                 clear_ibuffer,
  output logic                 can_fetch_inst
);

  localparam logic [PC_WIDTH-1:0] LINE_INC = PC_WIDTH'(LINE_BYTES);

  ifu_state_t           state_q, state_d;
  logic                 pending_q, pending_d;
  logic [PC_WIDTH-1:0]  pc_q, pc_d;
  logic [PC_WIDTH-1:0]  pc_index_q, pc_index_d;
  logic                 pc_index_valid_q, pc_index_valid_d;
  logic                 done_q, done_d;
  logic                 clear_q, clear_d;
  logic [LINE_BITS-1:0] fetch_line_q, fetch_line_d;
  logic [3:0]           start_slot_q, start_slot_d;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q          <= IDLE;
      pending_q        <= 1'b1;
      pc_q             <= RESET_PC;
      pc_index_q       <= RESET_PC;
      pc_index_valid_q <= 1'b0;
      done_q           <= 1'b0;
      clear_q          <= 1'b0;
      fetch_line_q     <= '0;
      start_slot_q     <= '0;
    end else begin
      state_q          <= state_d;
      pending_q        <= pending_d;
      pc_q             <= pc_d;
      pc_index_q       <= pc_index_d;
      pc_index_valid_q <= pc_index_valid_d;
      done_q           <= done_d;
      clear_q          <= clear_d;
      fetch_line_q     <= fetch_line_d;
      start_slot_q     <= start_slot_d;
    end
  end

  always_comb begin
    state_d          = state_q;
    pending_d        = pending_q;
    pc_d             = pc_q;
    pc_index_d       = pc_index_q;
    pc_index_valid_d = pc_index_valid_q;
    done_d           = 1'b0;
    clear_d          = redirect_valid;
    fetch_line_d     = fetch_line_q;
    start_slot_d     = start_slot_q;

    unique case (state_q)
      IDLE: begin
        // A same-cycle redirect wins; the pending flag re-issues later.
        if (!redirect_valid && (fetch_inst || pending_q)) begin
          state_d          = REQ;
          pending_d        = 1'b0;
          pc_index_d       = pc_q;
          pc_index_valid_d = 1'b1;
        end
      end
      REQ: begin
        if (pc_index_ready) begin
          pc_index_valid_d = 1'b0;
          if (redirect_valid) begin
            state_d = IDLE;
          end else begin
            fetch_line_d = pc_read_inst;
            done_d       = 1'b1;
            state_d      = DONE;
          end
        end else if (redirect_valid) begin
          // The arbiter cannot abort; let the stale read finish.
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (pc_index_ready) begin
          pc_index_valid_d = 1'b0;
          state_d          = IDLE;
        end
      end
      DONE: begin
        state_d      = IDLE;
        pc_d         = pc_q + LINE_INC;
        start_slot_d = '0;
      end
      default: state_d = IDLE;
    endcase

    if (redirect_valid) begin
      pc_d = {redirect_target[PC_WIDTH-1:LINE_OFFSET_BITS],
              {LINE_OFFSET_BITS{1'b0}}};
      start_slot_d = slot_of(redirect_target[LINE_OFFSET_BITS-1:0]);
      pending_d    = 1'b1;
    end
  end

  assign pc_index_valid    = pc_index_valid_q;
  assign pc_index          = pc_index_q;
  assign pc_operation_done = done_q;
  assign pc                = pc_q;
  assign fetch_line        = fetch_line_q;
  assign start_slot        = start_slot_q;
  assign clear_ibuffer     = clear_q;
  assign can_fetch_inst    = (state_q == IDLE) & ~pending_q
                             & ~redirect_valid;

endmodule

// File: tb/tb_ifu_line_fetcher.sv
// Directed self-checking bench for ifu_line_fetcher.
// Inputs change 1ns after the rising edge; outputs are checked there too.
module tb_ifu_line_fetcher;

  logic         clock = 1'b0;
  logic         reset;
  logic         fetch_inst;
  logic         redirect_valid;
  logic [47:0]  redirect_target;
  logic         pc_index_ready;
  logic [511:0] pc_read_inst;
  logic         pc_index_valid;
  logic [47:0]  pc_index;
  logic         pc_operation_done;
  logic [47:0]  pc;
  logic [511:0] fetch_line;
  logic [3:0]   start_slot;
  logic         clear_ibuffer;
  logic         can_fetch_inst;

  int tests = 0;
  int fails = 0;

  localparam logic [511:0] L0 = {16{32'hDEAD_0000}};
  localparam logic [511:0] L1 = {16{32'h1111_2222}};
  localparam logic [511:0] L2 = {16{32'hA5A5_0002}};
  localparam logic [511:0] L3 = {16{32'h3333_4444}};

  ifu_line_fetcher dut (
    .clock            (clock),
    .reset            (reset),
    .fetch_inst       (fetch_inst),
    .redirect_valid   (redirect_valid),
    .redirect_target  (redirect_target),
    .pc_index_ready   (pc_index_ready),
    .pc_read_inst     (pc_read_inst),
    .pc_index_valid   (pc_index_valid),
    .pc_index         (pc_index),
    .pc_operation_done(pc_operation_done),
    .pc               (pc),
    .fetch_line       (fetch_line),
    .start_slot       (start_slot),
    .clear_ibuffer    (clear_ibuffer),
    .can_fetch_inst   (can_fetch_inst)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [511:0] obs,
                     input logic [511:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic respond(input logic [511:0] d);
    pc_index_ready = 1'b1;
    pc_read_inst   = d;
    tick();
    pc_index_ready = 1'b0;
    pc_read_inst   = '0;
  endtask

  task automatic redirect(input logic [47:0] t);
    redirect_valid  = 1'b1;
    redirect_target = t;
    tick();
    redirect_valid  = 1'b0;
  endtask

  initial begin
    reset           = 1'b1;
    fetch_inst      = 1'b0;
    redirect_valid  = 1'b0;
    redirect_target = '0;
    pc_index_ready  = 1'b0;
    pc_read_inst    = '0;
    repeat (3) tick();

    // Reset state
    chk("rst_valid", 512'(pc_index_valid), 512'(0));
    chk("rst_pc", 512'(pc), 512'(0));
    chk("rst_done", 512'(pc_operation_done), 512'(0));
    chk("rst_clear", 512'(clear_ibuffer), 512'(0));
    chk("rst_line", fetch_line, 512'(0));
    chk("rst_slot", 512'(start_slot), 512'(0));
    chk("rst_canf", 512'(can_fetch_inst), 512'(0));

    // First fetch starts on its own after release
    reset = 1'b0;
    for (int i = 0; i < 4; i++)
      if (!pc_index_valid) tick();
    chk("boot_valid", 512'(pc_index_valid), 512'(1));
    chk("boot_addr", 512'(pc_index), 512'(0));
    repeat (3) begin
      tick();
      chk("boot_hold_v", 512'(pc_index_valid), 512'(1));
      chk("boot_hold_a", 512'(pc_index), 512'(0));
    end

    // Redirect to 0x2048 while the boot request is in flight
    redirect(48'h2048);
    chk("drn_clear", 512'(clear_ibuffer), 512'(1));
    chk("drn_valid", 512'(pc_index_valid), 512'(1));
    chk("drn_addr", 512'(pc_index), 512'(0));
    chk("drn_pc", 512'(pc), 512'(48'h2040));
    chk("drn_slot", 512'(start_slot), 512'(2));
    tick();
    chk("drn_clear0", 512'(clear_ibuffer), 512'(0));
    chk("drn_valid2", 512'(pc_index_valid), 512'(1));
    respond(L0);
    chk("drn_nodone", 512'(pc_operation_done), 512'(0));
    chk("drn_drop", 512'(pc_index_valid), 512'(0));
    tick();
    chk("rdr_valid", 512'(pc_index_valid), 512'(1));
    chk("rdr_addr", 512'(pc_index), 512'(48'h2040));
    respond(L1);
    chk("rdr_done", 512'(pc_operation_done), 512'(1));
    chk("rdr_pc", 512'(pc), 512'(48'h2040));
    chk("rdr_line", fetch_line, L1);
    chk("rdr_slot", 512'(start_slot), 512'(2));
    tick();
    chk("rdr_done0", 512'(pc_operation_done), 512'(0));
    chk("rdr_pcinc", 512'(pc), 512'(48'h2080));
    chk("rdr_slot0", 512'(start_slot), 512'(0));
    chk("idle_canf", 512'(can_fetch_inst), 512'(1));

    // Redirect and fetch together in IDLE: one request, redirect line
    fetch_inst = 1'b1;
    redirect(48'h0FC0);
    fetch_inst = 1'b0;
    chk("same_clear", 512'(clear_ibuffer), 512'(1));
    chk("same_novalid", 512'(pc_index_valid), 512'(0));
    tick();
    chk("same_valid", 512'(pc_index_valid), 512'(1));
    chk("same_addr", 512'(pc_index), 512'(48'h0FC0));
    respond(L2);
    tick();
    chk("same_pc", 512'(pc), 512'(48'h1000));
    repeat (3) tick();
    chk("same_once", 512'(pc_index_valid), 512'(0));

    // Plain fetch at 0x1000, response after 5 cycles
    fetch_inst = 1'b1;
    tick();
    fetch_inst = 1'b0;
    chk("f_valid", 512'(pc_index_valid), 512'(1));
    chk("f_addr", 512'(pc_index), 512'(48'h1000));
    chk("f_canf", 512'(can_fetch_inst), 512'(0));
    repeat (4) tick();
    chk("f_wait", 512'(pc_index_valid), 512'(1));
    respond(L3);
    chk("f_done", 512'(pc_operation_done), 512'(1));
    chk("f_pc", 512'(pc), 512'(48'h1000));
    chk("f_line", fetch_line, L3);
    tick();
    chk("f_single", 512'(pc_operation_done), 512'(0));
    fetch_inst = 1'b1;
    tick();
    fetch_inst = 1'b0;
    chk("f_next", 512'(pc_index), 512'(48'h1040));
    respond(L1);
    tick();

    // Redirect during the DONE cycle
    fetch_inst = 1'b1;
    tick();
    fetch_inst = 1'b0;
    respond(L2);
    chk("dn_done", 512'(pc_operation_done), 512'(1));
    chk("dn_pc_a", 512'(pc), 512'(48'h1080));
    redirect(48'h3004);
    chk("dn_clear", 512'(clear_ibuffer), 512'(1));
    chk("dn_done0", 512'(pc_operation_done), 512'(0));
    chk("dn_pc", 512'(pc), 512'(48'h3000));
    chk("dn_slot", 512'(start_slot), 512'(1));
    tick();
    chk("dn_addr", 512'(pc_index), 512'(48'h3000));
    respond(L0);
    tick();

    // Address wrap from the top line to zero
    redirect(48'hFFFF_FFFF_FFC0);
    tick();
    chk("wr_addr", 512'(pc_index), 512'(48'hFFFF_FFFF_FFC0));
    respond(L3);
    tick();
    chk("wr_pc", 512'(pc), 512'(0));
    fetch_inst = 1'b1;
    tick();
    fetch_inst = 1'b0;
    chk("wr_next", 512'(pc_index), 512'(0));
    chk("wr_valid", 512'(pc_index_valid), 512'(1));

    // Asynchronous reset mid-request
    #2 reset = 1'b1;
    #1;
    chk("ar_valid", 512'(pc_index_valid), 512'(0));
    chk("ar_pc", 512'(pc), 512'(0));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
